// File: rtl/display_page_scheduler_pkg.sv
// Shared types for the HEX display page scheduler: page/state encodings and
// the page-to-decoder-select mapping.
package display_pkg;

  typedef enum logic [1:0] {
    PAGE_TIME = 2'd0,
    PAGE_SEC  = 2'd1,
    PAGE_DAY  = 2'd2,
    PAGE_DATE = 2'd3
  } page_t;

  typedef enum logic [1:0] {
    S_FIXED  = 2'd0,
    S_AUTO   = 2'd1,
    S_MANUAL = 2'd2
  } state_t;

  function automatic logic [2:0] page_to_sel(page_t p);
    case (p)
      PAGE_SEC:  return 3'b001;
      PAGE_DAY:  return 3'b010;
      PAGE_DATE: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/display_page_scheduler_if.sv
// Board-side bundle of the page scheduler: switch/tick/mode inputs and the
// decoder-facing select, page and blank outputs.
interface display_page_scheduler_if;
  import display_pkg::*;

  logic       tick_1hz;
  logic [2:0] sw;
  logic       auto_en;
  logic       sync_valid;
  logic [2:0] sel;
  page_t      page;
  logic       blank;

  modport master (
    output tick_1hz, sw, auto_en, sync_valid,
    input  sel, page, blank
  );

  modport slave (
    input  tick_1hz, sw, auto_en, sync_valid,
    output sel, page, blank
  );

endinterface

// File: rtl/display_page_scheduler_switch_debounce.sv
// One switch bit: 2-FF synchronizer followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive mismatching cycles.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          meta_q;
  logic          sync_q;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (sync_q != dout_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/display_page_scheduler.sv
// Chooses the HEX display page: debounced switch override, else 1 Hz auto-rotation
// or fixed time page. Optional blink while DCF77 unlocked: define DISPLAY_BLINK_EN.
module display_page_scheduler
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned PAGE_DWELL_S    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  display_page_scheduler_if.slave  bus
);

  localparam int unsigned DW = $clog2(PAGE_DWELL_S + 1);

  logic [2:0] sw_db;

  genvar i;
  for (i = 0; i < 3; i++) begin : g_db
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.sw[i]),
      .dout    (sw_db[i])
    );
  end

  state_t        state_q, state_d;
  page_t         page_q,  page_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    sel_q;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    dwell_d = dwell_q;
    if (|sw_db) begin
      // Override path: a tick arriving here is simply dropped.
      state_d = S_MANUAL;
      dwell_d = '0;
      if (sw_db[0])      page_d = PAGE_SEC;
      else if (sw_db[1]) page_d = PAGE_DAY;
      else               page_d = PAGE_DATE;
    end else if (bus.auto_en) begin
      if (state_q != S_AUTO) begin
        state_d = S_AUTO;
        page_d  = PAGE_TIME;
        dwell_d = '0;
      end else if (bus.tick_1hz) begin
        if (dwell_q == DW'(PAGE_DWELL_S - 1)) begin
          page_d  = page_t'(page_q + 2'd1);
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
    end else begin
      state_d = S_FIXED;
      page_d  = PAGE_TIME;
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FIXED;
      page_q  <= PAGE_TIME;
      dwell_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      dwell_q <= dwell_d;
      sel_q   <= page_to_sel(page_d);
    end
  end

  assign bus.sel  = sel_q;
  assign bus.page = page_q;

`ifdef DISPLAY_BLINK_EN
  logic blank_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
    end else if (bus.sync_valid) begin
      blank_q <= 1'b0;
    end else if (bus.tick_1hz) begin
      blank_q <= ~blank_q;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = 1'b0;
`endif

endmodule
